// File: rtl/adder_serial.sv
// adder_serial: multi-cycle WIDTH-bit adder/subtractor that consumes DIGIT
// bits per clock. An operation starts with a Start/Busy/Done handshake and
// reports Sum, Carry and Overflow. Overflow uses either the signed or the
// unsigned rule.
module adder_serial #(
  parameter int WIDTH = 4,
  parameter int DIGIT = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Sub,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  // Number of RUN cycles and the width of the digit counter.
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] opa_reg, opb_reg;
  logic [WIDTH-1:0] stage_reg;
  logic             cy_reg;
  logic             sub_reg, sgn_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg, ovf_reg, done_reg;

  logic             accept;
  logic             last;
  logic [DIGIT:0]   dsum;
  logic             cin_msb;
  logic [WIDTH-1:0] stage_next;
  logic             ovf_next;

  assign accept = (state_reg == IDLE) && Start;
  assign last   = (cnt_reg == CW'(N - 1));

  // Add one digit. The result is DIGIT sum bits plus the carry out in the top bit.
  assign dsum = {1'b0, opa_reg[DIGIT-1:0]} + {1'b0, opb_reg[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, cy_reg};

  // Carry into the MSB of the word. This is only meaningful on the last digit.
  // It is the carry out of the low DIGIT-1 bits of that digit.
  generate
    if (DIGIT == 1) begin : g_cin_single
      assign cin_msb = cy_reg;
    end else begin : g_cin_multi
      logic [DIGIT-1:0] low_sum;
      assign low_sum = {1'b0, opa_reg[DIGIT-2:0]} + {1'b0, opb_reg[DIGIT-2:0]}
                     + {{(DIGIT-1){1'b0}}, cy_reg};
      assign cin_msb = low_sum[DIGIT-1];
    end
  endgenerate

  // Each new digit enters the staging register at the MSB end.
  // After N digits it holds the full word.
  generate
    if (DIGIT == WIDTH) begin : g_stage_full
      assign stage_next = dsum[DIGIT-1:0];
    end else begin : g_stage_shift
      assign stage_next = {dsum[DIGIT-1:0], stage_reg[WIDTH-1:DIGIT]};
    end
  endgenerate

  // Choose the overflow rule from the Sub and Signed values latched at accept.
  always_comb begin
    ovf_next = 1'b0;
    if (sgn_reg)
      ovf_next = cin_msb ^ dsum[DIGIT];
    else if (sub_reg)
      ovf_next = ~dsum[DIGIT];
    else
      ovf_next = dsum[DIGIT];
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // FSM next state: enter RUN on accept, return to IDLE after the last digit.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    Busy = (state_reg == RUN);
  end

  // Datapath: load operands on accept, then process one digit per RUN cycle.
  // Retire the result on the last digit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_reg   <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      stage_reg <= '0;
      cy_reg    <= 1'b0;
      sub_reg   <= 1'b0;
      sgn_reg   <= 1'b0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        // Subtraction is A + ~B + 1. The +1 comes in as the initial carry.
        opa_reg <= A;
        opb_reg <= Sub ? ~B : B;
        cy_reg  <= Sub;
        sub_reg <= Sub;
        sgn_reg <= Signed;
        cnt_reg <= '0;
      end else if (state_reg == RUN) begin
        opa_reg   <= opa_reg >> DIGIT;
        opb_reg   <= opb_reg >> DIGIT;
        stage_reg <= stage_next;
        cy_reg    <= dsum[DIGIT];
        cnt_reg   <= cnt_reg + 1'b1;
        if (last) begin
          sum_reg   <= stage_next;
          carry_reg <= dsum[DIGIT];
          ovf_reg   <= ovf_next;
          done_reg  <= 1'b1;
        end
      end
    end
  end

  assign Done     = done_reg;
  assign Sum      = sum_reg;
  assign Carry    = carry_reg;
  assign Overflow = ovf_reg;

endmodule

// File: tb/tb_adder_serial.sv
// Directed testbench for adder_serial. It uses a 4-bit/1-digit instance and
// an 8-bit/4-digit instance.
module tb_adder_serial;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       start4, sub4, sgn4, busy4, done4, carry4, ovf4;
  logic [3:0] a4, b4, sum4;
  logic       start8, sub8, sgn8, busy8, done8, carry8, ovf8;
  logic [7:0] a8, b8, sum8;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 Clk = ~Clk;

  adder_serial #(.WIDTH(4), .DIGIT(1)) u4 (
    .Clk(Clk), .Reset(Reset), .Start(start4), .Sub(sub4), .Signed(sgn4),
    .A(a4), .B(b4), .Busy(busy4), .Done(done4), .Sum(sum4),
    .Carry(carry4), .Overflow(ovf4)
  );

  adder_serial #(.WIDTH(8), .DIGIT(4)) u8 (
    .Clk(Clk), .Reset(Reset), .Start(start8), .Sub(sub8), .Signed(sgn8),
    .A(a8), .B(b8), .Busy(busy8), .Done(done8), .Sum(sum8),
    .Carry(carry8), .Overflow(ovf8)
  );

  // Run one operation on the 4-bit instance. Operands are scrambled after
  // accept. lat counts cycles from the accept edge to Done.
  task automatic do_op4(input logic [3:0] a, input logic [3:0] b,
                        input logic sub, input logic sgn,
                        output logic [3:0] s, output logic c, output logic o,
                        output int lat, output int busy_n);
    a4 = a; b4 = b; sub4 = sub; sgn4 = sgn; start4 = 1'b1;
    @(posedge Clk); #1;
    start4 = 1'b0; a4 = ~a; b4 = ~b; sub4 = ~sub; sgn4 = ~sgn;
    lat = 0; busy_n = 0;
    while (!done4 && lat < 20) begin
      if (busy4) busy_n++;
      @(posedge Clk); #1;
      lat++;
    end
    s = sum4; c = carry4; o = ovf4;
    $display("op4 a=%0d b=%0d sub=%0b sgn=%0b -> sum=%0d carry=%0b ovf=%0b lat=%0d busy=%0d",
             a, b, sub, sgn, s, c, o, lat, busy_n);
  endtask

  // Run one operation on the 8-bit instance.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                        input logic sub, input logic sgn,
                        output logic [7:0] s, output logic c, output logic o,
                        output int lat, output int busy_n);
    a8 = a; b8 = b; sub8 = sub; sgn8 = sgn; start8 = 1'b1;
    @(posedge Clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b; sub8 = ~sub; sgn8 = ~sgn;
    lat = 0; busy_n = 0;
    while (!done8 && lat < 20) begin
      if (busy8) busy_n++;
      @(posedge Clk); #1;
      lat++;
    end
    s = sum8; c = carry8; o = ovf8;
    $display("op8 a=0x%02h b=0x%02h sub=%0b sgn=%0b -> sum=0x%02h carry=%0b ovf=%0b lat=%0d busy=%0d",
             a, b, sub, sgn, s, c, o, lat, busy_n);
  endtask

  task automatic test_reset;
    Reset = 1'b1; start4 = 1'b1; start8 = 1'b1;
    a4 = 4'd3; b4 = 4'd3; a8 = 8'd3; b8 = 8'd3;
    repeat (3) @(posedge Clk);
    #1;
    chk_cnt++;
    if ({busy4, done4, sum4, carry4, ovf4} !== 8'd0)
      $display("FAIL reset4 got busy=%0b done=%0b sum=%0d c=%0b o=%0b want all 0",
               busy4, done4, sum4, carry4, ovf4);
    else pass_cnt++;
    chk_cnt++;
    if ({busy8, done8, sum8, carry8, ovf8} !== 12'd0)
      $display("FAIL reset8 got busy=%0b done=%0b sum=%0h c=%0b o=%0b want all 0",
               busy8, done8, sum8, carry8, ovf8);
    else pass_cnt++;
    start4 = 1'b0; start8 = 1'b0; Reset = 1'b0;
    @(posedge Clk); #1;
    chk_cnt++;
    if (busy4 !== 1'b0) $display("FAIL reset_start_ignored got busy=%0b want 0", busy4);
    else pass_cnt++;
  endtask

  task automatic test_unsigned_add;
    logic [3:0] s; logic c, o; int lat, bn;
    do_op4(4'd5, 4'd15, 1'b0, 1'b0, s, c, o, lat, bn);
    chk_cnt++; if (s !== 4'd4) $display("FAIL uadd_sum got %0d want 4", s); else pass_cnt++;
    chk_cnt++; if (c !== 1'b1) $display("FAIL uadd_carry got %0b want 1", c); else pass_cnt++;
    chk_cnt++; if (o !== 1'b1) $display("FAIL uadd_ovf got %0b want 1", o); else pass_cnt++;
    chk_cnt++; if (lat !== 4) $display("FAIL uadd_latency got %0d want 4", lat); else pass_cnt++;
    chk_cnt++; if (bn !== 4) $display("FAIL uadd_busy_cycles got %0d want 4", bn); else pass_cnt++;
    @(posedge Clk); #1;
    chk_cnt++; if (done4 !== 1'b0) $display("FAIL uadd_done_pulse got %0b want 0", done4); else pass_cnt++;
    chk_cnt++; if (sum4 !== 4'd4) $display("FAIL uadd_sum_hold got %0d want 4", sum4); else pass_cnt++;
  endtask

  task automatic test_signed_add;
    logic [3:0] s; logic c, o; int lat, bn;
    do_op4(4'd5, 4'd15, 1'b0, 1'b1, s, c, o, lat, bn);
    chk_cnt++; if (s !== 4'd4) $display("FAIL sadd1_sum got %0d want 4", s); else pass_cnt++;
    chk_cnt++; if (o !== 1'b0) $display("FAIL sadd1_ovf got %0b want 0", o); else pass_cnt++;
    do_op4(4'd7, 4'd1, 1'b0, 1'b1, s, c, o, lat, bn);
    chk_cnt++; if (s !== 4'd8) $display("FAIL sadd2_sum got %0d want 8", s); else pass_cnt++;
    chk_cnt++; if (o !== 1'b1) $display("FAIL sadd2_ovf got %0b want 1", o); else pass_cnt++;
    chk_cnt++; if (c !== 1'b0) $display("FAIL sadd2_carry got %0b want 0", c); else pass_cnt++;
  endtask

  task automatic test_subtract;
    logic [3:0] s; logic c, o; int lat, bn;
    do_op4(4'd3, 4'd5, 1'b1, 1'b0, s, c, o, lat, bn);
    chk_cnt++; if (s !== 4'd14) $display("FAIL usub_sum got %0d want 14", s); else pass_cnt++;
    chk_cnt++; if (c !== 1'b0) $display("FAIL usub_carry got %0b want 0", c); else pass_cnt++;
    chk_cnt++; if (o !== 1'b1) $display("FAIL usub_ovf got %0b want 1", o); else pass_cnt++;
    do_op4(4'd3, 4'd5, 1'b1, 1'b1, s, c, o, lat, bn);
    chk_cnt++; if (s !== 4'd14) $display("FAIL ssub_sum got %0d want 14", s); else pass_cnt++;
    chk_cnt++; if (o !== 1'b0) $display("FAIL ssub_ovf got %0b want 0", o); else pass_cnt++;
  endtask

  task automatic test_digit4;
    logic [7:0] s; logic c, o; int lat, bn;
    do_op8(8'h7F, 8'h01, 1'b0, 1'b1, s, c, o, lat, bn);
    chk_cnt++; if (s !== 8'h80) $display("FAIL d4add_sum got 0x%02h want 0x80", s); else pass_cnt++;
    chk_cnt++; if (o !== 1'b1) $display("FAIL d4add_ovf got %0b want 1", o); else pass_cnt++;
    chk_cnt++; if (c !== 1'b0) $display("FAIL d4add_carry got %0b want 0", c); else pass_cnt++;
    chk_cnt++; if (lat !== 2) $display("FAIL d4add_latency got %0d want 2", lat); else pass_cnt++;
    chk_cnt++; if (bn !== 2) $display("FAIL d4add_busy_cycles got %0d want 2", bn); else pass_cnt++;
    do_op8(8'h80, 8'h01, 1'b1, 1'b1, s, c, o, lat, bn);
    chk_cnt++; if (s !== 8'h7F) $display("FAIL d4sub_sum got 0x%02h want 0x7f", s); else pass_cnt++;
    chk_cnt++; if (c !== 1'b1) $display("FAIL d4sub_carry got %0b want 1", c); else pass_cnt++;
    chk_cnt++; if (o !== 1'b1) $display("FAIL d4sub_ovf got %0b want 1", o); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int k;
    a4 = 4'd1; b4 = 4'd2; sub4 = 1'b0; sgn4 = 1'b0; start4 = 1'b1;
    @(posedge Clk); #1;
    a4 = 4'd9; b4 = 4'd3; sub4 = 1'b1;
    k = 0;
    while (!done4 && k < 20) begin @(posedge Clk); #1; k++; end
    $display("b2b op1 a=1 b=2 -> sum=%0d lat=%0d", sum4, k);
    chk_cnt++; if (k !== 4) $display("FAIL b2b1_latency got %0d want 4", k); else pass_cnt++;
    chk_cnt++; if (sum4 !== 4'd3) $display("FAIL b2b1_sum got %0d want 3", sum4); else pass_cnt++;
    a4 = 4'd6; b4 = 4'd7; sub4 = 1'b0;
    @(posedge Clk); #1;
    chk_cnt++; if (busy4 !== 1'b1) $display("FAIL b2b2_accept got busy=%0b want 1", busy4); else pass_cnt++;
    chk_cnt++; if (done4 !== 1'b0) $display("FAIL b2b_done_twice got %0b want 0", done4); else pass_cnt++;
    chk_cnt++; if (sum4 !== 4'd3) $display("FAIL b2b_sum_hold got %0d want 3", sum4); else pass_cnt++;
    a4 = 4'd2; b4 = 4'd2;
    k = 0;
    while (!done4 && k < 20) begin @(posedge Clk); #1; k++; end
    $display("b2b op2 a=6 b=7 -> sum=%0d lat=%0d", sum4, k);
    chk_cnt++; if (k !== 4) $display("FAIL b2b2_latency got %0d want 4", k); else pass_cnt++;
    chk_cnt++; if (sum4 !== 4'd13) $display("FAIL b2b2_sum got %0d want 13", sum4); else pass_cnt++;
    start4 = 1'b0;
    @(posedge Clk); #1;
    chk_cnt++; if (busy4 !== 1'b0) $display("FAIL b2b_stop got busy=%0b want 0", busy4); else pass_cnt++;
  endtask

  task automatic test_ignore_start;
    int k;
    a4 = 4'd2; b4 = 4'd3; sub4 = 1'b0; sgn4 = 1'b0; start4 = 1'b1;
    @(posedge Clk); #1;
    start4 = 1'b0;
    @(posedge Clk); #1;
    start4 = 1'b1; a4 = 4'd15; b4 = 4'd15; sub4 = 1'b1;
    @(posedge Clk); #1;
    start4 = 1'b0;
    k = 2;
    while (!done4 && k < 20) begin @(posedge Clk); #1; k++; end
    $display("ign op a=2 b=3 with mid-run start -> sum=%0d lat=%0d", sum4, k);
    chk_cnt++; if (k !== 4) $display("FAIL ign_latency got %0d want 4", k); else pass_cnt++;
    chk_cnt++; if (sum4 !== 4'd5) $display("FAIL ign_sum got %0d want 5", sum4); else pass_cnt++;
    @(posedge Clk); #1;
    chk_cnt++; if (busy4 !== 1'b0) $display("FAIL ign_no_queue got busy=%0b want 0", busy4); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run;
    logic [3:0] s; logic c, o; int lat, bn;
    do_op4(4'd5, 4'd15, 1'b0, 1'b0, s, c, o, lat, bn);
    a4 = 4'd2; b4 = 4'd3; sub4 = 1'b0; sgn4 = 1'b0; start4 = 1'b1;
    @(posedge Clk); #1;
    start4 = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk_cnt++; if (sum4 !== 4'd4) $display("FAIL rst_pre_sum got %0d want 4", sum4); else pass_cnt++;
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk_cnt++;
    if ({busy4, done4, sum4, carry4, ovf4} !== 8'd0)
      $display("FAIL rst_mid_outputs got busy=%0b done=%0b sum=%0d c=%0b o=%0b want all 0",
               busy4, done4, sum4, carry4, ovf4);
    else pass_cnt++;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    chk_cnt++;
    if ({busy4, done4} !== 2'b00)
      $display("FAIL rst_after got busy=%0b done=%0b want 0 0", busy4, done4);
    else pass_cnt++;
    do_op4(4'd9, 4'd8, 1'b0, 1'b0, s, c, o, lat, bn);
    chk_cnt++; if (s !== 4'd1) $display("FAIL rst_resume_sum got %0d want 1", s); else pass_cnt++;
    chk_cnt++; if ({c, o} !== 2'b11) $display("FAIL rst_resume_flags got c=%0b o=%0b want 1 1", c, o); else pass_cnt++;
    chk_cnt++; if (lat !== 4) $display("FAIL rst_resume_latency got %0d want 4", lat); else pass_cnt++;
  endtask

  initial begin
    Reset = 1'b1;
    start4 = 1'b0; sub4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sub8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    test_reset;
    test_unsigned_add;
    test_signed_add;
    test_subtract;
    test_digit4;
    test_back_to_back;
    test_ignore_start;
    test_reset_mid_run;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
